async_fifo_rd_ctrl: RTL and testbench
=====================================

# async_fifo_rd_ctrl

Read-side control stage of the asynchronous FIFO, in the read clock domain. It consumes the write pointer, already Gray-coded by the write side and passed through the two-flop synchronizer. It produces the read address for the dual-port memory, a registered Gray-coded read pointer for the write domain, and the empty, almost-empty, fill-level and read-data-valid status. It is the read-domain counterpart of the write-pointer/full-flag generator and shares its pointer width convention: address bits plus one wrap bit.

## Interface
- addr_width, 4, memory address width; FIFO depth = 2^addr_width; pointers are addr_width+1 bits
- almost_empty_th, 2, almost_empty asserts when the fill level is at or below this value
- r_clk  input  1  read-domain clock; all state updates on its rising edge
- r_rst_n  input  1  reset, asynchronous, active-low
- r_inc  input  1  read request; accepted only when empty_flag is 0
- sync_grey_coded_wr_ptr  input  addr_width+1  write pointer, Gray-coded, already synchronized into r_clk
- rd_ptr_grey_coded  output  addr_width+1  registered Gray read pointer, sent to the write-domain synchronizer
- r_address  output  addr_width  memory read address = low addr_width bits of the binary read pointer
- empty_flag  output  1  registered; 1 = no readable entry
- almost_empty  output  1  registered; 1 = rd_level <= almost_empty_th
- rd_level  output  addr_width+1  registered fill level seen from the read domain, 0..2^addr_width
- rd_valid  output  1  one-cycle pulse, one cycle after an accepted read; memory read data is valid in that cycle

## Operation
- Accept = r_inc && !empty_flag. A request while empty is ignored: no pointer change, no rd_valid.
- rd_bin_next = rd_bin + Accept, modulo 2^(addr_width+1).
- gray(x) = x ^ (x >> 1).
- Write-pointer binary: wr_bin[addr_width] = g[addr_width]; wr_bin[i] = wr_bin[i+1] ^ g[i] for i downward.
- On each r_clk edge:
  - rd_bin <= rd_bin_next
  - rd_ptr_grey_coded <= gray(rd_bin_next)
  - empty_flag <= (gray(rd_bin_next) == sync_grey_coded_wr_ptr)
  - rd_level <= (wr_bin - rd_bin_next), modulo 2^(addr_width+1)
  - almost_empty <= (that level <= almost_empty_th)
  - rd_valid <= Accept
- rd_ptr_grey_coded comes straight from a register, so it is glitch-free; only one bit changes per increment.
- Wrap-around: the pointer rolls from 2^(addr_width+1)-1 to 0. The Gray code is continuous across the roll and the level arithmetic stays modulo-correct.
- Level 2^addr_width is legal and means the read side sees the FIFO full. The block generates no full indication.
- Simultaneous read and write-pointer change: both are used in the same next-state computation, with no priority between them.
- The synchronized write pointer only increases. Any value it takes is treated as legal; no error checking.

## Timing
- Reset (async assert, any time, including mid-read) forces:
  - rd_bin = 0, r_address = 0, rd_ptr_grey_coded = 0
  - rd_level = 0, rd_valid = 0
  - empty_flag = 1, almost_empty = 1
- Deassertion is released synchronously to r_clk by the upstream reset synchronizer.
- Write-pointer update to status: 1 r_clk cycle (empty_flag, rd_level and almost_empty reflect it after the next edge).
- Read to pointer: the accepted read updates r_address and rd_ptr_grey_coded at the same edge.
- rd_valid is high in the cycle after the accepted read.
- Last-entry read: empty_flag is 1 at the edge that consumes the last entry, so a back-to-back r_inc in the next cycle is ignored.
- Sustained throughput: one read per cycle while not empty.
- All outputs are registered; no combinational path from input to output.

## Test plan
- Reset values: hold r_rst_n=0 with r_inc=1 and sync_grey_coded_wr_ptr=5'b00011 -> all outputs at their reset values listed under Timing (empty_flag=1, almost_empty=1, everything else 0); assert reset asynchronously mid-cycle -> outputs clear immediately.
- Single entry: after reset, set sync ptr to gray(1)=5'b00001 -> next cycle empty_flag=0, rd_level=1, almost_empty=1; pulse r_inc -> r_address=1, rd_ptr_grey_coded=5'b00001, empty_flag=1, rd_level=0; rd_valid=1 exactly one cycle later.
- Read while empty: r_inc=1 for 5 cycles with sync ptr 0 -> r_address stays 0, rd_valid stays 0.
- Full depth and drain: set sync ptr to gray(16)=5'b11000 -> rd_level=16, almost_empty=0; 16 consecutive reads -> r_address runs 1..15 then 0; almost_empty rises when rd_level=2; empty_flag=1 after the 16th read; the 17th r_inc is ignored.
- Wrap-around: 40 writes and 40 reads interleaved -> the read pointer passes 31->0, rd_ptr_grey_coded at pointer 31 is 5'b10000 and at 0 is 5'b00000, and rd_level stays correct throughout.
- Simultaneous events, then reset: with rd_level=3, read and advance sync ptr by 1 in the same cycle -> rd_level stays 3; then assert r_rst_n=0 during a burst -> state returns to reset values, and the first read after release is blocked until sync ptr is nonzero.

Source files
------------

// File: rtl/async_fifo_rd_ctrl_if.sv
// rtl/async_fifo_rd_ctrl_if.sv - read-side FIFO control bus
// Signals:
//   r_inc                  read request from the consumer
//   sync_grey_coded_wr_ptr write pointer (Gray), already in the read clock domain
//   rd_ptr_grey_coded      registered Gray read pointer toward the write domain
//   r_address              dual-port memory read address
//   empty_flag             no readable entry
//   almost_empty           fill level at or below threshold
//   rd_level               fill level seen from the read domain
//   rd_valid               memory read data valid this cycle
// master: the consumer/write-side environment; slave: the read controller.
interface async_fifo_rd_ctrl_if #(
   parameter int addr_width = 4
);
   logic                  r_inc;
   logic [addr_width:0]   sync_grey_coded_wr_ptr;
   logic [addr_width:0]   rd_ptr_grey_coded;
   logic [addr_width-1:0] r_address;
   logic                  empty_flag;
   logic                  almost_empty;
   logic [addr_width:0]   rd_level;
   logic                  rd_valid;

   modport master (
      output r_inc, sync_grey_coded_wr_ptr,
      input  rd_ptr_grey_coded, r_address, empty_flag, almost_empty, rd_level, rd_valid
   );

   modport slave (
      input  r_inc, sync_grey_coded_wr_ptr,
      output rd_ptr_grey_coded, r_address, empty_flag, almost_empty, rd_level, rd_valid
   );
endinterface

// File: rtl/async_fifo_rd_ctrl.sv
// rtl/async_fifo_rd_ctrl.sv - async FIFO read pointer, empty and level generator
// Ports:
//   r_clk    read-domain clock
//   r_rst_n  asynchronous active-low reset (release is synchronous upstream)
//   bus      async_fifo_rd_ctrl_if.slave: read request, synchronized write
//            pointer in; read address, Gray read pointer and status out
// Pointers are addr_width+1 bits: address bits plus one wrap bit.
module async_fifo_rd_ctrl #(
   parameter int addr_width      = 4,
   parameter int almost_empty_th = 2
) (
   input  logic                 r_clk,
   input  logic                 r_rst_n,
   async_fifo_rd_ctrl_if.slave  bus
);
   localparam int PW = addr_width + 1;
   localparam logic [PW-1:0] AE_TH = PW'(almost_empty_th);

   logic [PW-1:0] r_rd_bin;
   logic [PW-1:0] r_rd_gray;
   logic          r_empty;
   logic          r_almost_empty;
   logic [PW-1:0] r_level;
   logic          r_valid;

   logic          w_accept;
   logic [PW-1:0] w_rd_bin_next;
   logic [PW-1:0] w_rd_gray_next;
   logic [PW-1:0] w_wr_bin;
   logic [PW-1:0] w_level_next;

   // The registered empty flag gates the request, so the edge that consumes
   // the last entry already blocks a back-to-back request in the next cycle.
   assign w_accept       = bus.r_inc & ~r_empty;
   assign w_rd_bin_next  = r_rd_bin + {{addr_width{1'b0}}, w_accept};
   assign w_rd_gray_next = w_rd_bin_next ^ (w_rd_bin_next >> 1);

   // Gray to binary: bit i is the XOR of all Gray bits at or above i.
   always_comb begin
      w_wr_bin = '0;
      for (int i = 0; i < PW; i++) begin
         w_wr_bin[i] = ^(bus.sync_grey_coded_wr_ptr >> i);
      end
   end

   // Modulo subtraction keeps the level correct across the pointer wrap.
   assign w_level_next = w_wr_bin - w_rd_bin_next;

   always_ff @(posedge r_clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_rd_bin       <= '0;
         r_rd_gray      <= '0;
         r_empty        <= 1'b1;
         r_almost_empty <= 1'b1;
         r_level        <= '0;
         r_valid        <= 1'b0;
      end else begin
         r_rd_bin       <= w_rd_bin_next;
         r_rd_gray      <= w_rd_gray_next;
         r_empty        <= (w_rd_gray_next == bus.sync_grey_coded_wr_ptr);
         r_almost_empty <= (w_level_next <= AE_TH);
         r_level        <= w_level_next;
         r_valid        <= w_accept;
      end
   end

   assign bus.r_address         = r_rd_bin[addr_width-1:0];
   assign bus.rd_ptr_grey_coded = r_rd_gray;
   assign bus.empty_flag        = r_empty;
   assign bus.almost_empty      = r_almost_empty;
   assign bus.rd_level          = r_level;
   assign bus.rd_valid          = r_valid;
endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// tb/tb_async_fifo_rd_ctrl.sv - self-checking bench for async_fifo_rd_ctrl
module tb_async_fifo_rd_ctrl;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;
   localparam int PMOD  = 2 * DEPTH;
   localparam int AE_TH = 2;

   logic r_clk;
   logic r_rst_n;

   async_fifo_rd_ctrl_if #(.addr_width(AW)) bus ();

   async_fifo_rd_ctrl #(.addr_width(AW), .almost_empty_th(AE_TH)) dut (
      .r_clk   (r_clk),
      .r_rst_n (r_rst_n),
      .bus     (bus)
   );

   initial r_clk = 1'b0;
   always #5 r_clk = ~r_clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: total entries written and read as plain counts.
   int m_wr;
   int m_rd;
   int m_lvl;
   bit m_empty;
   bit m_ae;
   bit m_valid;

   function automatic int gray(input int x);
      return x ^ (x >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".r_address"},    32'(bus.r_address),         32'(m_rd % DEPTH));
      chk({tag, ".rd_ptr_gray"},  32'(bus.rd_ptr_grey_coded), 32'(gray(m_rd % PMOD)));
      chk({tag, ".empty_flag"},   32'(bus.empty_flag),        32'(m_empty));
      chk({tag, ".almost_empty"}, 32'(bus.almost_empty),      32'(m_ae));
      chk({tag, ".rd_level"},     32'(bus.rd_level),          32'(m_lvl));
      chk({tag, ".rd_valid"},     32'(bus.rd_valid),          32'(m_valid));
   endtask

   task automatic set_wr(input int n);
      m_wr = n;
      bus.sync_grey_coded_wr_ptr = (AW+1)'(gray(n % PMOD));
   endtask

   task automatic model_reset();
      m_rd    = 0;
      m_lvl   = 0;
      m_empty = 1'b1;
      m_ae    = 1'b1;
      m_valid = 1'b0;
   endtask

   // One read-clock edge; the model updates from the inputs held at that edge.
   task automatic tick();
      bit acc;
      @(posedge r_clk);
      if (!r_rst_n) begin
         model_reset();
      end else begin
         acc = bus.r_inc && m_empty == 1'b0;
         if (acc) m_rd++;
         m_valid = acc;
         m_lvl   = m_wr - m_rd;
         m_empty = (m_lvl == 0);
         m_ae    = (m_lvl <= AE_TH);
      end
      #1;
   endtask

   // Reset asserted between edges must clear outputs without a clock.
   task automatic mid_reset(input string tag);
      r_rst_n = 1'b0;
      #1;
      model_reset();
      check_all(tag);
   endtask

   initial begin
      int  writes;
      int  reads;
      int  cyc;
      bit  seen31;
      bit  seen_wrap;

      model_reset();
      m_wr    = 0;
      r_rst_n = 1'b0;
      bus.r_inc = 1'b1;
      set_wr(2);  // Gray 5'b00011
      repeat (3) tick();
      check_all("reset_hold");

      r_rst_n = 1'b1;
      bus.r_inc = 1'b0;
      set_wr(0);
      tick();
      check_all("after_release");

      // Single entry
      set_wr(1);
      tick();
      check_all("single_avail");
      bus.r_inc = 1'b1;
      tick();
      check_all("single_read");
      chk("single_gray_const", 32'(bus.rd_ptr_grey_coded), 32'h01);
      bus.r_inc = 1'b0;
      tick();
      check_all("single_valid_drop");

      // Read while empty
      bus.r_inc = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_all("empty_read");
      end
      bus.r_inc = 1'b0;

      // Full depth and drain, starting from a fresh reset
      mid_reset("async_rst_1");
      set_wr(0);
      tick();
      r_rst_n = 1'b1;
      set_wr(DEPTH);
      tick();
      check_all("full_level");
      chk("full_level_const", 32'(bus.rd_level), 32'd16);
      bus.r_inc = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) begin
         tick();
         check_all("drain");
      end
      chk("drain_17th_ignored", 32'(bus.r_address), 32'd0);
      bus.r_inc = 1'b0;

      // Wrap-around: 40 writes and 40 reads randomly interleaved
      writes = 0; reads = 0; cyc = 0; seen31 = 0; seen_wrap = 0;
      while ((writes < 40 || reads < 40) && cyc < 600) begin
         if (writes < 40 && (m_wr - m_rd) < DEPTH && $urandom_range(0, 3) != 0) begin
            set_wr(m_wr + 1);
            writes++;
         end
         bus.r_inc = ($urandom_range(0, 3) != 0);
         tick();
         cyc++;
         if (m_valid) reads++;
         check_all("wrap");
         if (m_valid && (m_rd % PMOD) == PMOD - 1) begin
            seen31 = 1'b1;
            chk("gray_at_31", 32'(bus.rd_ptr_grey_coded), 32'h10);
         end
         if (m_valid && seen31 && (m_rd % PMOD) == 0) begin
            seen_wrap = 1'b1;
            chk("gray_at_0", 32'(bus.rd_ptr_grey_coded), 32'h00);
         end
      end
      chk("wrap_reads_done", 32'(reads), 32'd40);
      chk("wrap_seen", 32'(seen_wrap), 32'd1);

      // Simultaneous read and write-pointer advance at level 3
      bus.r_inc = 1'b1;
      cyc = 0;
      while (!m_empty && cyc < 40) begin
         tick();
         cyc++;
      end
      bus.r_inc = 1'b0;
      set_wr(m_wr + 3);
      tick();
      check_all("lvl3");
      bus.r_inc = 1'b1;
      set_wr(m_wr + 1);
      tick();
      check_all("simul");
      chk("simul_level_const", 32'(bus.rd_level), 32'd3);

      // Reset in the middle of a read burst
      for (int i = 0; i < 3; i++) begin
         set_wr(m_wr + 1);
         tick();
         check_all("burst");
      end
      mid_reset("async_rst_burst");
      set_wr(0);
      repeat (2) tick();
      check_all("burst_rst_hold");
      r_rst_n = 1'b1;
      repeat (2) begin
         tick();
         check_all("blocked_after_rst");
      end
      set_wr(1);
      tick();
      check_all("first_avail");
      tick();
      check_all("first_read");
      chk("first_read_valid_const", 32'(bus.rd_valid), 32'd1);
      bus.r_inc = 1'b0;
      tick();
      check_all("final");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
